// File: rtl/score_display.sv
// Multiplexed seven-segment driver for the reaction-game status: per-frame snapshot,
// last/best alternation in finish mode, ghost-guarded digit scan. Optional SCORE_DISP_LZB_EN.
`timescale 1ns/1ps
module score_display #(
  parameter int DIGITS     = 6,
  parameter int SCAN_DIV   = 4000,
  parameter int ALT_CYCLES = 40_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [2:0]            i_dst,
  input  logic [4*DIGITS-1:0]   i_last,
  input  logic [4*DIGITS-1:0]   i_best,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an
);

  localparam int PW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IW = (DIGITS > 1)     ? $clog2(DIGITS)     : 1;
  localparam int AW = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;

  localparam logic [PW-1:0] PRE_END = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_END = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_SUB = IW'(DIGITS - 2);
  localparam logic [IW-1:0] DP_DIG  = IW'(3);
  localparam logic [AW-1:0] ALT_END = AW'(ALT_CYCLES - 1);

  localparam logic [2:0] D_IDLE   = 3'b000;
  localparam logic [2:0] D_GUARD  = 3'b001;
  localparam logic [2:0] D_MEAS   = 3'b010;
  localparam logic [2:0] D_EARLY  = 3'b011;
  localparam logic [2:0] D_FINISH = 3'b110;

  localparam logic [6:0] G_DASH  = 7'h40;
  localparam logic [6:0] G_E     = 7'h79;
  localparam logic [6:0] G_R     = 7'h50;
  localparam logic [6:0] G_BLANK = 7'h00;

  typedef enum logic {LAST = 1'b0, BEST = 1'b1} phase_t;

  logic [PW-1:0]            pre;
  logic [IW-1:0]            idx;
  logic [2:0]               s_dst;
  logic [DIGITS-1:0][3:0]   s_last, s_best;
  logic [AW-1:0]            alt_cnt, alt_nxt;
  phase_t                   phase, phase_nxt;

  logic pre_end, frame_end;
  assign pre_end   = (pre == PRE_END);
  assign frame_end = pre_end && (idx == IDX_END);

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hF: glyph = G_DASH;
      default: glyph = G_BLANK;
    endcase
  endfunction

  // scan timing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre_end) begin
      pre <= '0;
      idx <= (idx == IDX_END) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // tear-free snapshot, refreshed only at the last cycle of a frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_dst  <= D_IDLE;
      s_last <= '1;
      s_best <= '1;
    end else if (frame_end) begin
      s_dst  <= i_dst;
      s_last <= i_last;
      s_best <= i_best;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alt_cnt <= '0;
      phase   <= LAST;
    end else begin
      alt_cnt <= alt_nxt;
      phase   <= phase_nxt;
    end
  end

  // outside finish mode the alternation is parked so finish always opens on LAST
  always_comb begin
    alt_nxt   = '0;
    phase_nxt = LAST;
    if (s_dst == D_FINISH) begin
      if (alt_cnt == ALT_END) begin
        alt_nxt   = '0;
        phase_nxt = (phase == LAST) ? BEST : LAST;
      end else begin
        alt_nxt   = alt_cnt + 1'b1;
        phase_nxt = phase;
      end
    end
  end

  logic [DIGITS-1:0][3:0] val;
  logic [3:0]             nib;
  logic                   zb, lit;
  logic [6:0]             seg_nxt;
  logic                   dp_nxt;
  logic [DIGITS-1:0]      an_nxt;

  always_comb begin
    val     = (s_dst == D_FINISH && phase == LAST) ? s_last : s_best;
    nib     = val[idx];
    lit     = 1'b1;
    seg_nxt = G_BLANK;
    dp_nxt  = 1'b0;
    an_nxt  = '0;
`ifdef SCORE_DISP_LZB_EN
    zb = (nib == 4'h0) &&
         ((idx == IDX_END) || (idx == IDX_SUB && val[DIGITS-1] == 4'h0));
`else
    zb = 1'b0;
`endif
    case (s_dst)
      D_IDLE, D_FINISH: begin
        seg_nxt = zb ? G_BLANK : glyph(nib);
        dp_nxt  = (idx == DP_DIG) ||
                  (s_dst == D_FINISH && phase == BEST && idx == IDX_END);
      end
      D_GUARD: seg_nxt = G_DASH;
      D_EARLY: begin
        case (idx)
          IW'(2):        seg_nxt = G_E;
          IW'(1), IW'(0): seg_nxt = G_R;
          default:       seg_nxt = G_BLANK;
        endcase
      end
      D_MEAS:  lit = 1'b0;
      default: lit = 1'b0;
    endcase
    // ghost guard: first cycle of each slot is dark, segments included
    if (lit && pre != '0) begin
      an_nxt = DIGITS'(1) << idx;
    end else begin
      seg_nxt = G_BLANK;
      dp_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg <= '0;
      o_dp  <= 1'b0;
      o_an  <= '0;
    end else begin
      o_seg <= seg_nxt;
      o_dp  <= dp_nxt;
      o_an  <= an_nxt;
    end
  end

endmodule
